// File: rtl/mcu_mem_arbiter.sv
// Arbitrates the MCU cache port and the DMA engine onto one memory
// controller command port, and re-times refill data for the cache.
module mcu_mem_arbiter #(
  parameter int READ_LAT = 4,
  parameter int RBUF_W   = 32
) (
  input  logic              MCU_CLK,
  input  logic              RST,
  input  logic [31:0]       mem_addr,
  input  logic              mem_we,
  input  logic              mem_do_act,
  input  logic [RBUF_W-1:0] mem_dataintomem,
  output logic              mem_ack,
  output logic [RBUF_W-1:0] mem_datafrommem,
  output logic              dma_mcu_access,
  input  logic              dma_req,
  input  logic              dma_we,
  input  logic [31:0]       dma_addr,
  input  logic [RBUF_W-1:0] dma_wdata,
  output logic              dma_ack,
  output logic [RBUF_W-1:0] dma_rdata,
  output logic              ctl_cmd_valid,
  input  logic              ctl_cmd_ready,
  output logic              ctl_we,
  output logic              ctl_len2,
  output logic [31:0]       ctl_addr,
  output logic [RBUF_W-1:0] ctl_wdata,
  input  logic              ctl_rvalid,
  input  logic [RBUF_W-1:0] ctl_rdata
);

  localparam int CW = $clog2(READ_LAT + 2);
  localparam logic [CW-1:0] C_ONE = CW'(1);
  localparam logic [CW-1:0] C_LM1 = CW'(READ_LAT - 1);
  localparam logic [CW-1:0] C_LAT = CW'(READ_LAT);
  localparam logic [CW-1:0] C_LP1 = CW'(READ_LAT + 1);

  typedef enum logic [2:0] {
    IDLE,
    CPU_CMD,
    CPU_COLLECT,
    CPU_REPLAY,
    ACK_HOLD,
    DMA_CMD,
    DMA_WAIT
  } state_e;

  state_e              state_q, state_d;
  logic                last_dma_q, last_dma_d;
  logic [CW-1:0]       cnt_q, cnt_d;
  logic                beat_q, beat_d;
  logic [RBUF_W-1:0]   buf0_q, buf0_d;
  logic [RBUF_W-1:0]   buf1_q, buf1_d;
  logic [RBUF_W-1:0]   rdata_q, rdata_d;
  logic                we_q, we_d;
  logic                len2_q, len2_d;
  logic [31:0]         addr_q, addr_d;
  logic [RBUF_W-1:0]   wdata_q, wdata_d;
  logic                grant_dma;

  always_ff @(posedge MCU_CLK or posedge RST) begin
    if (RST) begin
      state_q    <= IDLE;
      last_dma_q <= 1'b1;
      cnt_q      <= '0;
      beat_q     <= 1'b0;
      buf0_q     <= '0;
      buf1_q     <= '0;
      rdata_q    <= '0;
      we_q       <= 1'b0;
      len2_q     <= 1'b0;
      addr_q     <= '0;
      wdata_q    <= '0;
    end else begin
      state_q    <= state_d;
      last_dma_q <= last_dma_d;
      cnt_q      <= cnt_d;
      beat_q     <= beat_d;
      buf0_q     <= buf0_d;
      buf1_q     <= buf1_d;
      rdata_q    <= rdata_d;
      we_q       <= we_d;
      len2_q     <= len2_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
    end
  end

  always_comb begin
    state_d       = state_q;
    last_dma_d    = last_dma_q;
    cnt_d         = cnt_q;
    beat_d        = beat_q;
    buf0_d        = buf0_q;
    buf1_d        = buf1_q;
    rdata_d       = rdata_q;
    we_d          = we_q;
    len2_d        = len2_q;
    addr_d        = addr_q;
    wdata_d       = wdata_q;
    grant_dma     = 1'b0;
    mem_ack       = 1'b0;
    dma_ack       = 1'b0;
    dma_rdata     = '0;
    ctl_cmd_valid = 1'b0;
    unique case (state_q)
      IDLE: begin
        // Round-robin: a tie goes to the side not granted last
        if (mem_do_act && (!dma_req || last_dma_q)) begin
          state_d    = CPU_CMD;
          last_dma_d = 1'b0;
          we_d       = mem_we;
          len2_d     = !mem_we;
          addr_d     = mem_addr;
          wdata_d    = mem_dataintomem;
        end else if (dma_req) begin
          grant_dma  = 1'b1;
          state_d    = DMA_CMD;
          last_dma_d = 1'b1;
          we_d       = dma_we;
          len2_d     = 1'b0;
          addr_d     = dma_addr;
          wdata_d    = dma_wdata;
        end
      end
      CPU_CMD: begin
        ctl_cmd_valid = 1'b1;
        if (ctl_cmd_ready) begin
          if (we_q) begin
            mem_ack = 1'b1;
            cnt_d   = '0;
            state_d = ACK_HOLD;
          end else begin
            beat_d  = 1'b0;
            state_d = CPU_COLLECT;
          end
        end
      end
      CPU_COLLECT: begin
        if (ctl_rvalid) begin
          if (!beat_q) begin
            buf0_d = ctl_rdata;
            beat_d = 1'b1;
          end else begin
            buf1_d  = ctl_rdata;
            cnt_d   = '0;
            state_d = CPU_REPLAY;
          end
        end
      end
      CPU_REPLAY: begin
        // Count 0 is the ack cycle; words land at READ_LAT and READ_LAT+1
        mem_ack = (cnt_q == '0);
        cnt_d   = cnt_q + C_ONE;
        if (cnt_q == C_LM1) rdata_d = buf0_q;
        if (cnt_q == C_LAT) rdata_d = buf1_q;
        if (cnt_q == C_LP1) state_d = IDLE;
      end
      ACK_HOLD: begin
        cnt_d = cnt_q + C_ONE;
        if (cnt_q == C_ONE) state_d = IDLE;
      end
      DMA_CMD: begin
        ctl_cmd_valid = 1'b1;
        if (ctl_cmd_ready) begin
          if (we_q) begin
            dma_ack = 1'b1;
            state_d = IDLE;
          end else begin
            state_d = DMA_WAIT;
          end
        end
      end
      DMA_WAIT: begin
        if (ctl_rvalid) begin
          dma_ack   = 1'b1;
          dma_rdata = ctl_rdata;
          state_d   = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign dma_mcu_access = RST || !(grant_dma
                                   || state_q == DMA_CMD
                                   || state_q == DMA_WAIT);
  assign mem_datafrommem = rdata_q;
  assign ctl_we          = we_q;
  assign ctl_len2        = len2_q;
  assign ctl_addr        = addr_q;
  assign ctl_wdata       = wdata_q;

endmodule
